// File: rtl/gpr_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_pkg
// Brief    : Shared constants, types and helpers for the GPR writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package gpr_wb_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int XLEN_DEFAULT   = 32;
  localparam int NUM_GPRS_RV32E = 16;
  localparam int NUM_GPRS_RV32I = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

  function automatic logic is_legal_gpr(input logic [REG_ADDR_W-1:0] addr,
                                        input int unsigned num_gprs);
    return ({{(32-REG_ADDR_W){1'b0}}, addr} < num_gprs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : gpr_rr_arbiter
// Brief    : Combinational round-robin picker: first valid at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && valid[j]) begin
        grant_valid = 1'b1;
        grant[j]    = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Brief    : Round-robin arbiter sharing the GPR write port, registered output.
//            Optional per-requester conflict counters: GPR_WB_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_GPRS = NUM_GPRS_RV32E,
  parameter int XLEN     = XLEN_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          rf_stall,
  output logic                          rf_wr_en,
  output logic [REG_ADDR_W-1:0]         rf_wr_addr,
  output logic [XLEN-1:0]               rf_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          illegal_wr
`ifdef GPR_WB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         conflict_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    w_cand;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_hs;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_legal;
  logic                  w_commit;

  // Stall removes every candidate, so it blocks grants and freezes ptr together.
  assign w_cand = rf_stall ? '0 : req_valid;

  gpr_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid       (w_cand),
    .ptr         (r_ptr),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_hs)
  );

  assign req_ready  = resetn ? w_grant : '0;
  assign w_sel_addr = req_addr[int'(w_grant_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_sel_data = req_data[int'(w_grant_idx)*XLEN +: XLEN];
  assign w_legal    = is_legal_gpr(w_sel_addr, NUM_GPRS);
  assign w_commit   = w_legal && (w_sel_addr != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr      <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      grant_id   <= '0;
      illegal_wr <= 1'b0;
    end else if (w_hs) begin
      r_ptr    <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      grant_id <= w_grant_idx;
      rf_wr_en <= w_commit;
      // Dropped writes leave addr/data untouched so the bus holds its last beat.
      if (w_commit) begin
        rf_wr_addr <= w_sel_addr;
        rf_wr_data <= w_sel_data;
      end
      if (!w_legal) illegal_wr <= 1'b1;
    end else begin
      rf_wr_en <= 1'b0;
    end
  end

`ifdef GPR_WB_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
      end else if (req_valid[gi] && !req_ready[gi] && !rf_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign conflict_cnt[gi*32 +: 32] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Brief    : Directed self-checking bench for gpr_wb_arbiter (NUM_REQ=3, RV32E).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int NUM_GPRS = 16;
  localparam int XLEN     = 32;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*5-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic                 rf_stall;
  logic                 rf_wr_en;
  logic [4:0]           rf_wr_addr;
  logic [XLEN-1:0]      rf_wr_data;
  logic [1:0]           grant_id;
  logic                 illegal_wr;
`ifdef GPR_WB_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gpr_wb_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_GPRS (NUM_GPRS),
    .XLEN     (XLEN)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_stall   (rf_stall),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .grant_id   (grant_id),
    .illegal_wr (illegal_wr)
`ifdef GPR_WB_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]           = v;
    req_addr[i*5 +: 5]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    resetn    = 1'b0;
    rf_stall  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset state, with requests present to show ready is held low.
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    #12;
    check("rst_ready", req_ready, 3'b000);
    check("rst_en", rf_wr_en, 1'b0);
    check("rst_addr", rf_wr_addr, 5'd0);
    check("rst_data", rf_wr_data, 32'h0);
    check("rst_gid", grant_id, 2'd0);
    check("rst_ill", illegal_wr, 1'b0);
    req_valid = '0;
    tick();
    resetn = 1'b1;
    tick();

    // Single write from requester 0.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check("single_en", rf_wr_en, 1'b1);
    check("single_addr", rf_wr_addr, 5'd5);
    check("single_data", rf_wr_data, 32'hDEADBEEF);
    check("single_gid", grant_id, 2'd0);
    tick();
    check("idle_en", rf_wr_en, 1'b0);
    check("idle_hold_addr", rf_wr_addr, 5'd5);
    check("idle_hold_data", rf_wr_data, 32'hDEADBEEF);

    // Fairness from reset with all three requesters continuously valid.
    pulse_reset();
    set_req(0, 1'b1, 5'd1, 32'hA0);
    set_req(1, 1'b1, 5'd2, 32'hA1);
    set_req(2, 1'b1, 5'd3, 32'hA2);
    for (int k = 0; k < 6; k++) begin
      exp_g = 2'(k % 3);
      #1;
      check("rr_ready", req_ready, 3'b001 << exp_g);
      tick();
      check("rr_en", rf_wr_en, 1'b1);
      check("rr_gid", grant_id, exp_g);
      check("rr_addr", rf_wr_addr, 5'(exp_g + 1));
      check("rr_data", rf_wr_data, 32'hA0 + exp_g);
    end
    req_valid = '0;

    // x0 write: accepted, no strobe, no flag. ptr is 0 here.
    set_req(1, 1'b1, 5'd0, 32'h55);
    #1;
    check("x0_ready", req_ready, 3'b010);
    tick();
    check("x0_en", rf_wr_en, 1'b0);
    check("x0_ill", illegal_wr, 1'b0);
    // Out-of-range write: dropped and flagged.
    set_req(1, 1'b1, 5'd20, 32'h66);
    #1;
    check("oor_ready", req_ready, 3'b010);
    tick();
    check("oor_en", rf_wr_en, 1'b0);
    check("oor_ill", illegal_wr, 1'b1);
    check("oor_hold_addr", rf_wr_addr, 5'd3);
    // Following legal write still flagged.
    set_req(1, 1'b1, 5'd7, 32'h77);
    tick();
    req_valid = '0;
    check("legal_en", rf_wr_en, 1'b1);
    check("legal_addr", rf_wr_addr, 5'd7);
    check("sticky_ill", illegal_wr, 1'b1);
    tick();

    // Stall: a grant from the cycle before still issues; then nothing moves.
    pulse_reset();
    set_req(2, 1'b1, 5'd9, 32'h99);
    tick();
    req_valid = '0;
    rf_stall  = 1'b1;
    set_req(0, 1'b1, 5'd10, 32'hB0);
    set_req(2, 1'b1, 5'd11, 32'hB2);
    check("stall_prev_en", rf_wr_en, 1'b1);
    check("stall_prev_addr", rf_wr_addr, 5'd9);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_ready", req_ready, 3'b000);
      tick();
      check("stall_en", rf_wr_en, 1'b0);
    end
    rf_stall = 1'b0;
    #1;
    check("rel_ready0", req_ready, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    check("rel_gid0", grant_id, 2'd0);
    check("rel_addr0", rf_wr_addr, 5'd10);
    #1;
    check("rel_ready2", req_ready, 3'b100);
    tick();
    req_valid = '0;
    check("rel_gid2", grant_id, 2'd2);
    check("rel_en2", rf_wr_en, 1'b1);
    check("rel_addr2", rf_wr_addr, 5'd11);

    // Reset mid-operation. ptr is 0: set the flag via req1, then req2 writes.
    set_req(1, 1'b1, 5'd31, 32'hCC);
    tick();
    req_valid = '0;
    check("mid_ill_set", illegal_wr, 1'b1);
    set_req(2, 1'b1, 5'd4, 32'h44);
    tick();
    check("mid_pre_en", rf_wr_en, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_en", rf_wr_en, 1'b0);
    check("mid_rst_ill", illegal_wr, 1'b0);
    check("mid_rst_ready", req_ready, 3'b000);
    resetn = 1'b1;
    #1;
    check("mid_post_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    check("mid_post_en", rf_wr_en, 1'b1);
    check("mid_post_gid", grant_id, 2'd2);
    check("mid_post_addr", rf_wr_addr, 5'd4);

`ifdef GPR_WB_ARB_PERF_EN
    // Conflict counters: req0/req1 alternate for four cycles.
    pulse_reset();
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(1, 1'b1, 5'd2, 32'h2);
    for (int k = 0; k < 4; k++) tick();
    req_valid = '0;
    check("perf_cnt0", conflict_cnt[31:0], 32'd2);
    check("perf_cnt1", conflict_cnt[63:32], 32'd2);
    check("perf_cnt2", conflict_cnt[95:64], 32'd0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR-file write port between NUM_REQ writeback requesters, e.g. 0 = ALU, 1 = LSU, 2 = CSR/debug.
- Uses round-robin arbitration and valid/ready handshakes, with one registered output stage driving the register file.
- Drops writes to x0. Drops and flags writes to registers beyond NUM_GPRS (RV32E = 16, RV32I = 32).
- Sits between the execute/LSU writeback stages and the GPR file whose contents feed the DPI register-dump path.

Parameters:
- NUM_REQ, 3: number of writeback requesters (2..8).
- NUM_GPRS, 16: implemented GPR count; legal values are 16 and 32.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept.
- req_addr  in  NUM_REQ*5  destination register index; requester i uses bits [5i+4:5i].
- req_data  in  NUM_REQ*XLEN  write data; requester i uses bits [XLEN*i+XLEN-1:XLEN*i].
- rf_stall  in  1  register file locked (snapshot/debug access); freezes arbitration.
- rf_wr_en  out  1  GPR write strobe.
- rf_wr_addr  out  5  GPR write index.
- rf_wr_data  out  XLEN  GPR write data.
- grant_id  out  $clog2(NUM_REQ)  requester that owns the current rf_wr_* beat.
- illegal_wr  out  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- Reset (resetn low, asynchronous):
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, illegal_wr=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - req_ready is combinational and is 0 while in reset.
- Arbitration (combinational, each cycle with rf_stall=0):
  - Grant the first valid requester found searching from ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[g]=1 for the granted requester only. All others get 0.
  - Handshake occurs when req_valid & req_ready.
- Pointer update: on a handshake, ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. No handshake leaves ptr unchanged.
- Output stage: registered, one-cycle latency.
  - Handshake in cycle N drives rf_wr_* and grant_id in cycle N+1.
  - rf_wr_en is a one-cycle pulse per accepted write.
  - Back-to-back grants give one write per cycle.
  - rf_wr_addr/rf_wr_data hold their last value when rf_wr_en=0.
- x0 writes: accepted (ready=1) and consume the grant plus pointer advance, but rf_wr_en stays 0 in N+1. illegal_wr is not set.
- Out-of-range writes (addr >= NUM_GPRS): accepted and dropped (rf_wr_en=0), and illegal_wr <= 1. illegal_wr is cleared only by reset.
- rf_stall=1:
  - All req_ready=0 and ptr is frozen.
  - The output stage emits rf_wr_en=0.
  - A write registered in the previous cycle still issues, because stall only gates new grants.
  - Requesters must hold valid, addr and data stable until ready.
- No valid requesters: rf_wr_en=0 next cycle; ptr unchanged.
- Reset mid-operation: a pending registered write is discarded (rf_wr_en forced 0). Requests held across reset are re-arbitrated from ptr=0.
- Valid-but-not-granted requesters must be served within NUM_REQ grant cycles (starvation-free).

Optional Feature:
- Macro GPR_WB_ARB_PERF_EN.
- With the macro defined:
  - Adds output conflict_cnt, NUM_REQ*32 bits.
  - Per-requester 32-bit saturating counter, incremented each cycle req_valid[i]=1 and req_ready[i]=0 with rf_stall=0.
  - Counters reset to 0 and saturate at 0xFFFF_FFFF.
- Without the macro: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package gpr_wb_pkg holds:
  - REG_ADDR_W=5, XLEN_DEFAULT=32.
  - NUM_GPRS_RV32E=16, NUM_GPRS_RV32I=32.
  - typedef wb_req_t {addr, data}.
  - Function is_legal_gpr(addr, num_gprs).
- Sub-module gpr_rr_arbiter: a parameterised round-robin picker (valid vector + ptr in, one-hot grant + index out, purely combinational). The top holds ptr, the output register and the flags.

Test Plan:
- Single write: req0 writes addr=5, data=0xDEADBEEF → next cycle rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, grant_id=0.
- Fairness with NUM_REQ=3: all three valid continuously, starting from reset → grants 0,1,2,0,1,2, with one rf_wr_en pulse per cycle for 6 cycles.
- x0 and out-of-range with NUM_GPRS=16:
  - req1 writes addr=0 → ready=1, rf_wr_en=0, illegal_wr=0.
  - Then req1 writes addr=20 → rf_wr_en=0, illegal_wr=1, which stays 1 after further legal writes.
- Stall:
  - req0 and req2 valid, rf_stall=1 for 4 cycles → no ready, no rf_wr_en, ptr frozen.
  - Release → req0 granted, then req2.
- Reset mid-operation:
  - Assert resetn=0 asynchronously the cycle after a handshake → rf_wr_en is 0 immediately and illegal_wr is cleared.
  - After release, a held req2 is granted once ptr=0 finds no valid req0/req1.
- Perf, with GPR_WB_ARB_PERF_EN: req0 and req1 valid for 4 cycles → conflict_cnt[1]=2 and conflict_cnt[0]=2 after the alternating grants.
